// File: rtl/bw_io_ddr_ctl_pkg.sv
// Shared types and constants for the DDR vref update controller.
package bw_io_ddr_ctl_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_QUIET = 3'd1,
    SETTLE     = 3'd2,
    STROBE     = 3'd3,
    HOLD       = 3'd4
  } state_t;

  // Requester indices into the two-bit request/grant vectors.
  localparam logic CAL = 1'b0;
  localparam logic CSR = 1'b1;

  localparam logic [7:0] VREF_RST_DEFAULT = 8'h80;

endpackage

// File: rtl/bw_io_ddr_rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves only when a grant is issued.
module bw_io_ddr_rr_arb2
  import bw_io_ddr_ctl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_l,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic last;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (req[CAL] && req[CSR]) begin
        grant = (last == CAL) ? 2'b10 : 2'b01;
      end else begin
        grant = req;
      end
    end
  end

  // Reset value CSR makes the calibration engine the first winner.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      last <= CSR;
    end else if (grant[CAL]) begin
      last <= CAL;
    end else if (grant[CSR]) begin
      last <= CSR;
    end
  end

endmodule

// File: rtl/bw_io_ddr_vref_upd_ctl.sv
// Arbitrates vref code updates from calibration and CSR, waits for a quiet bus,
// drives the code, strobes the pads after settling and acks after a hold time.
module bw_io_ddr_vref_upd_ctl
  import bw_io_ddr_ctl_pkg::*;
#(
  parameter int         SETTLE_CYC = 4,
  parameter int         HOLD_CYC   = 2,
  parameter logic [7:0] VREF_RST   = VREF_RST_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       req_cal,
  input  logic [7:0] code_cal,
  input  logic       req_csr,
  input  logic [7:0] code_csr,
  input  logic       bus_quiet,
  output logic [7:0] vref_code,
  output logic       upd_en,
  output logic       ack_cal,
  output logic       ack_csr,
  output logic       busy,
  output state_t     dbg_state
);

  if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle
    $error("SETTLE_CYC must be in 1..15");
  end
  if (HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_hold
    $error("HOLD_CYC must be in 1..15");
  end

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

  // Handshake: req is a level held by the requester; it is eligible in IDLE
  // only while its ack is low. ack is a one-cycle pulse ending the transaction.

  state_t     state, next_state;
  logic [7:0] code_q, next_code_q;
  logic [7:0] next_vref;
  logic [3:0] cnt, next_cnt;
  logic       winner, next_winner;
  logic       next_upd, next_ack_cal, next_ack_csr;
  logic [1:0] grant;

  bw_io_ddr_rr_arb2 u_arb (
    .clk   (clk),
    .rst_l (rst_l),
    .en    (state == IDLE),
    .req   ({req_csr & ~ack_csr, req_cal & ~ack_cal}),
    .grant (grant)
  );

  always_comb begin
    next_state   = state;
    next_code_q  = code_q;
    next_winner  = winner;
    next_vref    = vref_code;
    next_cnt     = cnt;
    next_upd     = 1'b0;
    next_ack_cal = 1'b0;
    next_ack_csr = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant[CAL]) begin
          next_code_q = code_cal;
          next_winner = CAL;
          next_state  = WAIT_QUIET;
        end else if (grant[CSR]) begin
          next_code_q = code_csr;
          next_winner = CSR;
          next_state  = WAIT_QUIET;
        end
      end
      WAIT_QUIET: begin
        if (bus_quiet) begin
          if (code_q != vref_code) begin
            next_vref  = code_q;
            next_cnt   = SETTLE_LD;
            next_state = SETTLE;
          end else begin
            next_ack_cal = (winner == CAL);
            next_ack_csr = (winner == CSR);
            next_state   = IDLE;
          end
        end
      end
      SETTLE: begin
        if (cnt == 4'd0) begin
          next_upd   = 1'b1;
          next_state = STROBE;
        end else begin
          next_cnt = cnt - 4'd1;
        end
      end
      STROBE: begin
        next_cnt   = HOLD_LD;
        next_state = HOLD;
      end
      HOLD: begin
        if (cnt == 4'd0) begin
          next_ack_cal = (winner == CAL);
          next_ack_csr = (winner == CSR);
          next_state   = IDLE;
        end else begin
          next_cnt = cnt - 4'd1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state     <= IDLE;
      code_q    <= 8'h00;
      winner    <= CAL;
      vref_code <= VREF_RST;
      cnt       <= 4'd0;
      upd_en    <= 1'b0;
      ack_cal   <= 1'b0;
      ack_csr   <= 1'b0;
    end else begin
      state     <= next_state;
      code_q    <= next_code_q;
      winner    <= next_winner;
      vref_code <= next_vref;
      cnt       <= next_cnt;
      upd_en    <= next_upd;
      ack_cal   <= next_ack_cal;
      ack_csr   <= next_ack_csr;
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_bw_io_ddr_vref_upd_ctl.sv
// Scoreboard bench for the vref update controller: directed requests push
// expected pulses; a monitor pops them as upd_en/ack pulses appear.
module tb_bw_io_ddr_vref_upd_ctl;
  import bw_io_ddr_ctl_pkg::*;

  localparam logic [1:0] K_UPD = 2'd1;
  localparam logic [1:0] K_CAL = 2'd2;
  localparam logic [1:0] K_CSR = 2'd3;

  logic       clk = 1'b0;
  logic       rst_l = 1'b0;
  logic       req_cal = 1'b0;
  logic [7:0] code_cal = 8'h00;
  logic       req_csr = 1'b0;
  logic [7:0] code_csr = 8'h00;
  logic       bus_quiet = 1'b1;
  logic [7:0] vref_code;
  logic       upd_en, ack_cal, ack_csr, busy;
  state_t     dbg_state;

  logic [9:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  bw_io_ddr_vref_upd_ctl dut (
    .clk       (clk),
    .rst_l     (rst_l),
    .req_cal   (req_cal),
    .code_cal  (code_cal),
    .req_csr   (req_csr),
    .code_csr  (code_csr),
    .bus_quiet (bus_quiet),
    .vref_code (vref_code),
    .upd_en    (upd_en),
    .ack_cal   (ack_cal),
    .ack_csr   (ack_csr),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_l && (upd_en || ack_cal || ack_csr)) begin
      logic [1:0] kind;
      logic [9:0] act;
      check("pulse_exclusive", 32'($onehot0({upd_en, ack_cal, ack_csr})), 32'd1);
      kind = upd_en ? K_UPD : (ack_cal ? K_CAL : K_CSR);
      act  = {kind, vref_code};
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'(act), 32'd0);
      end else begin
        check("pulse_kind_code", 32'(act), 32'(exp_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic expect_txn(input logic [1:0] ack_kind, input logic [7:0] code, input bit upd);
    if (upd) exp_q.push_back({K_UPD, code});
    exp_q.push_back({ack_kind, code});
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      0: return ack_cal;
      1: return ack_csr;
      2: return dbg_state == WAIT_QUIET;
      default: return dbg_state == SETTLE;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int budget, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      hit = cond(sel);
    end
    if (!hit) check(name, 32'd0, 32'd1);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_l = 1'b0;
    req_cal = 1'b0;
    req_csr = 1'b0;
    #1;
    check("rst_vref", 32'(vref_code), 32'h80);
    check("rst_upd", 32'(upd_en), 32'd0);
    check("rst_acks", 32'({ack_cal, ack_csr}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
  endtask

  initial begin
    apply_reset();

    // csr asks for the reset code: update skipped, ack only
    expect_txn(K_CSR, 8'h80, 1'b0);
    @(negedge clk);
    req_csr = 1'b1; code_csr = 8'h80;
    wait_for(1, 30, "skip_ack_timeout");
    req_csr = 1'b0;
    check("skip_vref", 32'(vref_code), 32'h80);

    // cal 0x90: exact latency; req and code dropped after grant
    expect_txn(K_CAL, 8'h90, 1'b1);
    @(negedge clk);
    req_cal = 1'b1; code_cal = 8'h90;
    wait_for(2, 30, "t33_grant_timeout");
    req_cal = 1'b0; code_cal = 8'h55;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) check("t33_vref_next", 32'(vref_code), 32'h90);
      check("t33_upd_timing", 32'(upd_en), 32'(k == 5));
      check("t33_ack_timing", 32'(ack_cal), 32'(k == 8));
    end

    // csr 0x33 stalled by a busy bus for 20 cycles
    expect_txn(K_CSR, 8'h33, 1'b1);
    @(negedge clk);
    bus_quiet = 1'b0;
    req_csr = 1'b1; code_csr = 8'h33;
    wait_for(2, 30, "t35_grant_timeout");
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("t35_busy", 32'(busy), 32'd1);
      check("t35_no_upd", 32'(upd_en), 32'd0);
      check("t35_vref_hold", 32'(vref_code), 32'h90);
    end
    bus_quiet = 1'b1;
    wait_for(1, 30, "t35_ack_timeout");
    req_csr = 1'b0;

    // simultaneous requests: cal first, then csr
    expect_txn(K_CAL, 8'h10, 1'b1);
    expect_txn(K_CSR, 8'h20, 1'b1);
    @(negedge clk);
    req_cal = 1'b1; code_cal = 8'h10;
    req_csr = 1'b1; code_csr = 8'h20;
    wait_for(0, 40, "t34_cal_timeout");
    req_cal = 1'b0;
    wait_for(1, 40, "t34_csr_timeout");
    req_csr = 1'b0;
    check("t34_vref_final", 32'(vref_code), 32'h20);

    // reset during SETTLE aborts, then a repeated request completes
    @(negedge clk);
    req_cal = 1'b1; code_cal = 8'h44;
    wait_for(3, 30, "t37_settle_timeout");
    apply_reset();
    expect_txn(K_CAL, 8'h44, 1'b1);
    @(negedge clk);
    req_cal = 1'b1;
    wait_for(0, 40, "t37_ack_timeout");
    req_cal = 1'b0;

    // cal held high, csr re-requests periodically: grants alternate
    expect_txn(K_CSR, 8'h70, 1'b1);
    expect_txn(K_CAL, 8'h60, 1'b1);
    expect_txn(K_CSR, 8'h71, 1'b1);
    expect_txn(K_CAL, 8'h60, 1'b1);
    @(negedge clk);
    req_cal = 1'b1; code_cal = 8'h60;
    req_csr = 1'b1; code_csr = 8'h70;
    for (int i = 0; i < 2; i++) begin
      wait_for(1, 60, "t38_csr_timeout");
      req_csr = 1'b0;
      code_csr = 8'h71;
      if (i == 0) begin
        repeat (3) @(negedge clk);
        req_csr = 1'b1;
      end
    end
    wait_for(0, 60, "t38_cal_timeout");
    req_cal = 1'b0;

    repeat (10) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_idle", 32'(busy), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bw_io_ddr_vref_upd_ctl.md
BW_IO_DDR_VREF_UPD_CTL -- requirements
Module: bw_io_ddr_vref_upd_ctl

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 4: cycles from driving a new code to strobe, covering repeater-chain propagation (legal 1..15).
REQ-002 SHALL have parameter HOLD_CYC, default 2: cycles the code is held after the strobe before ack (legal 1..15).
REQ-003 SHALL have parameter VREF_RST, default 8'h80: vref_code value at reset.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst_l input 1, asynchronous active-low reset.
REQ-005 SHALL have port req_cal, input, 1: level update request from the periodic calibration engine.
REQ-006 SHALL have port code_cal, input, 8: code requested by the calibration engine.
REQ-007 SHALL have port req_csr, input, 1: level update request from the software CSR.
REQ-008 SHALL have port code_csr, input, 8: code requested by the CSR.
REQ-009 SHALL have port bus_quiet, input, 1: DRAM bus idle, update permitted.
REQ-010 SHALL have port vref_code, output, 8: registered code driven into the vref repeater chain.
REQ-011 SHALL have port upd_en, output, 1: one-cycle update strobe to the pads.
REQ-012 SHALL have ports ack_cal and ack_csr, outputs, 1 each: one-cycle completion pulses.
REQ-013 SHALL have port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-014 States SHALL be IDLE, WAIT_QUIET, SETTLE, STROBE and HOLD, one-hot or encoded.
REQ-015 In IDLE, a requester is eligible only if its req is 1 and its ack is 0 in that cycle.
REQ-016 In IDLE, arbitration SHALL be two-way round-robin: with both eligible, grant the one not granted last; after reset the calibration engine wins first.
REQ-017 On grant, the block SHALL latch the winner's code into code_q, record the winner and move to WAIT_QUIET on the next cycle.
REQ-018 In WAIT_QUIET with bus_quiet=0, the block SHALL stay in WAIT_QUIET indefinitely.
REQ-019 In WAIT_QUIET with bus_quiet=1 and code_q != vref_code, the block SHALL load vref_code<=code_q, load the counter with SETTLE_CYC-1 and go to SETTLE.
REQ-020 In WAIT_QUIET with bus_quiet=1 and code_q == vref_code, the block SHALL skip the update: no upd_en, winner's ack pulses next cycle, return to IDLE.
REQ-021 In SETTLE, the block SHALL decrement the counter and go to STROBE when it reaches 0.
REQ-022 In STROBE, upd_en SHALL be 1 for exactly that cycle; the counter loads HOLD_CYC-1 and the state goes to HOLD.
REQ-023 In HOLD, the block SHALL decrement the counter; at 0 it registers the winner's ack=1 for one cycle and returns to IDLE.
REQ-024 Latency from bus_quiet seen in WAIT_QUIET to upd_en SHALL be SETTLE_CYC+1 cycles; from upd_en to ack it SHALL be HOLD_CYC+1 cycles.
REQ-025 A req deasserted before grant SHALL be ignored; a req deasserted after grant SHALL not abort: the sequence completes and ack still pulses.
REQ-026 Code inputs SHALL be sampled only at grant; later changes have no effect on the transaction in flight.
REQ-027 vref_code SHALL change only on the WAIT_QUIET->SETTLE transition; upd_en and ack_* SHALL never be high together, and ack_cal and ack_csr SHALL never be high together.
REQ-028 The counter SHALL be 4 bits; out-of-range parameters SHALL be flagged by an elaboration-time assertion.

Reset
REQ-029 With rst_l=0, the block SHALL set state=IDLE, vref_code=VREF_RST, upd_en=0, ack_cal=0, ack_csr=0, busy=0, counter=0, code_q=0, and the round-robin pointer to favour the calibration engine.
REQ-030 Reset during any state SHALL abort the transaction with no ack; requesters re-request after reset.

Structure
REQ-031 Package bw_io_ddr_ctl_pkg SHALL hold the state type, requester index constants (CAL=0, CSR=1) and the default VREF_RST.
REQ-032 Arbitration SHALL be a sub-module bw_io_ddr_rr_arb2 (2 requests, update-on-grant pointer, one-hot grant); all other logic stays in the top module.

Verification
REQ-033 Reset, then req_cal=1, code_cal=8'h90, bus_quiet=1 -> vref_code=8'h90 one cycle after WAIT_QUIET, upd_en 5 cycles later, ack_cal 3 cycles after upd_en.
REQ-034 req_cal and req_csr rise in the same cycle, codes 8'h10 and 8'h20 -> cal served first, then csr; vref_code ends at 8'h20; exactly two upd_en pulses.
REQ-035 Grant with bus_quiet=0 for 20 cycles -> busy=1, vref_code unchanged, no upd_en; bus_quiet rises -> normal sequence.
REQ-036 req_csr with code_csr=8'h80 directly after reset -> no upd_en, ack_csr pulses, vref_code stays 8'h80.
REQ-037 rst_l=0 asserted in SETTLE -> outputs return to reset values immediately, no ack; after release a repeated request completes normally.
REQ-038 req_cal held high continuously while csr requests periodically -> grants alternate, csr never starved, no double ack.
